// File: rtl/usb_uvc_iso_scheduler_pkg.sv
// Shared types and constants for the UVC isochronous EP81 payload scheduler.
`timescale 1ns/1ps
package usb_uvc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR0,
    ST_HDR1,
    ST_PAYLOAD,
    ST_WAIT_SOF
  } uvc_state_t;

  localparam logic [7:0] UVC_HLE = 8'h02;

  // Bit positions inside the UVC bmHeaderInfo (BFH) byte
  localparam int unsigned BFH_FID = 0;
  localparam int unsigned BFH_EOF = 1;
  localparam int unsigned BFH_ERR = 6;
  localparam int unsigned BFH_EOH = 7;

endpackage

// File: rtl/usb_uvc_iso_scheduler_if.sv
// Byte-wide valid/ready stream used for the pixel source and the EP81 port.
`timescale 1ns/1ps
interface usb_uvc_iso_scheduler_if;
  logic [7:0] data;
  logic       valid;
  logic       ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/usb_uvc_iso_scheduler.sv
// Builds one UVC payload packet (2-byte header + pixel bytes) on EP81 per USB SOF.
`timescale 1ns/1ps
module usb_uvc_iso_scheduler
  import usb_uvc_pkg::*;
#(
  parameter int unsigned FRAME_BYTES = 460800,
  parameter int unsigned PACKET_SIZE = 802
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              stream_en,
  input  logic                              sof,
  usb_uvc_iso_scheduler_if.slave            px,
  usb_uvc_iso_scheduler_if.master           ep,
  output logic                              vf_sof,
  output logic                              frame_done,
  output logic                              underrun,
  output logic                              fid
);

  localparam int unsigned PAYLOAD_LEN = PACKET_SIZE - 2;
  localparam logic [31:0] FRAME_LEN   = 32'(FRAME_BYTES);
  localparam logic [31:0] PAYLOAD32   = 32'(PAYLOAD_LEN);

  uvc_state_t  state;
  logic [31:0] foff;
  logic [9:0]  bcnt;
  logic [9:0]  plen;
  logic        last;
  logic        err;

  logic        hs;
  logic        pkt_end;
  logic        frm_end;
  logic        busy;
  logic [31:0] foff_nxt;
  logic [31:0] rem;
  logic        nxt_last;
  logic [9:0]  nxt_plen;
  logic [7:0]  bfh;

  // foff_nxt already reflects a handshake in this cycle, so a packet restarted
  // by sof in the same cycle sizes itself from the post-handshake offset.
  always_comb begin
    hs       = (state == ST_PAYLOAD) && px.valid && ep.ready;
    pkt_end  = hs && ((bcnt + 10'd1) == plen);
    frm_end  = pkt_end && last;
    busy     = (state == ST_HDR0) || (state == ST_HDR1) || (state == ST_PAYLOAD);
    foff_nxt = frm_end ? '0 : (hs ? foff + 32'd1 : foff);
    rem      = FRAME_LEN - foff_nxt;
    nxt_last = (rem <= PAYLOAD32);
    nxt_plen = nxt_last ? 10'(rem) : 10'(PAYLOAD_LEN);
  end

  always_comb begin
    bfh          = '0;
    bfh[BFH_EOH] = 1'b1;
    bfh[BFH_ERR] = err;
    bfh[BFH_EOF] = last;
    bfh[BFH_FID] = fid;
  end

  always_comb begin
    ep.valid = 1'b0;
    ep.data  = '0;
    px.ready = 1'b0;
    case (state)
      ST_HDR0: begin
        ep.valid = 1'b1;
        ep.data  = UVC_HLE;
      end
      ST_HDR1: begin
        ep.valid = 1'b1;
        ep.data  = bfh;
      end
      ST_PAYLOAD: begin
        ep.valid = px.valid;
        ep.data  = px.data;
        px.ready = ep.ready;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      foff       <= '0;
      bcnt       <= '0;
      plen       <= '0;
      last       <= 1'b0;
      fid        <= 1'b0;
      err        <= 1'b0;
      vf_sof     <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      vf_sof     <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
      foff       <= foff_nxt;
      if (hs)
        bcnt <= bcnt + 10'd1;
      if (frm_end) begin
        fid        <= ~fid;
        err        <= 1'b0;
        frame_done <= 1'b1;
      end
      // sof overrides normal sequencing; a final handshake in the same cycle still completes
      if (sof) begin
        if (!stream_en) begin
          state <= ST_IDLE;
          foff  <= '0;
          err   <= 1'b0;
        end else begin
          state <= ST_HDR0;
          plen  <= nxt_plen;
          last  <= nxt_last;
          if (busy && !pkt_end) begin
            underrun <= 1'b1;
            err      <= 1'b1;
          end
        end
      end else begin
        case (state)
          ST_HDR0: if (ep.ready) state <= ST_HDR1;
          ST_HDR1: if (ep.ready) begin
            vf_sof <= (foff == '0);
            bcnt   <= '0;
            state  <= ST_PAYLOAD;
          end
          ST_PAYLOAD: if (pkt_end) state <= ST_WAIT_SOF;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_usb_uvc_iso_scheduler.sv
// Randomized bench for usb_uvc_iso_scheduler against a frame/packet-level model.
`timescale 1ns/1ps
module tb_usb_uvc_iso_scheduler;

  localparam int FRAME = 10;
  localparam int PSIZE = 6;
  localparam int PAY   = PSIZE - 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stream_en = 1'b0;
  logic sof = 1'b0;
  logic vf_sof, frame_done, underrun, fid;

  usb_uvc_iso_scheduler_if px_if ();
  usb_uvc_iso_scheduler_if ep_if ();

  usb_uvc_iso_scheduler #(.FRAME_BYTES(FRAME), .PACKET_SIZE(PSIZE)) dut (
    .clk        (clk),
    .rst        (rst),
    .stream_en  (stream_en),
    .sof        (sof),
    .px         (px_if),
    .ep         (ep_if),
    .vf_sof     (vf_sof),
    .frame_done (frame_done),
    .underrun   (underrun),
    .fid        (fid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model of stream position and header flags
  int m_foff = 0;
  bit m_fid  = 1'b0;
  bit m_err  = 1'b0;
  bit exp_vf = 1'b0;
  bit exp_fd = 1'b0;
  bit exp_un = 1'b0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk_pulses();
    checks++;
    if ({vf_sof, frame_done, underrun} !== {exp_vf, exp_fd, exp_un}) begin
      errors++;
      $display("FAIL pulses t=%0t: got vf/fd/un=%b%b%b want %b%b%b", $time,
               vf_sof, frame_done, underrun, exp_vf, exp_fd, exp_un);
    end
    exp_vf = 1'b0; exp_fd = 1'b0; exp_un = 1'b0;
  endtask

  task automatic chk_fid();
    checks++;
    if (fid !== m_fid) begin
      errors++;
      $display("FAIL fid: got %b want %b", fid, m_fid);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk_pulses();
      checks++;
      if (ep_if.valid !== 1'b0 || px_if.ready !== 1'b0) begin
        errors++;
        $display("FAIL idle: ep_valid=%b px_ready=%b want 0 0", ep_if.valid, px_if.ready);
      end
      @(posedge clk); #1;
    end
  endtask

  // One-cycle sof; the bench only issues it while not presenting a byte on EP81.
  task automatic issue_sof(input bit busy);
    sof = 1'b1; px_if.valid = 1'b0; ep_if.ready = 1'b0;
    @(negedge clk);
    chk_pulses();
    checks++;
    if (ep_if.valid !== 1'b0) begin
      errors++;
      $display("FAIL sof_ep_valid: got %b want 0", ep_if.valid);
    end
    @(posedge clk); #1;
    sof = 1'b0;
    if (stream_en) begin
      if (busy) begin
        m_err  = 1'b1;
        exp_un = 1'b1;
      end
    end else begin
      m_foff = 0;
      m_err  = 1'b0;
    end
  endtask

  // Runs the packet that the previous sof started, checking every EP81 byte.
  task automatic run_packet(input int abort_after, input int hold_hdr0, input bit sof_on_final,
                            input int unsigned vp, input int unsigned rp);
    int rem, plen, idx, cyc, hold;
    bit last, start0, hs;
    logic [7:0] bfh, exp_b;
    rem    = FRAME - m_foff;
    last   = (rem <= PAY);
    plen   = last ? rem : PAY;
    bfh    = 8'h80 | (m_err ? 8'h40 : 8'h00) | (last ? 8'h02 : 8'h00) | (m_fid ? 8'h01 : 8'h00);
    start0 = (m_foff == 0);
    idx = 0; cyc = 0; hold = 0;
    while (idx < plen + 2) begin
      if (cyc >= 300) begin
        checks++; errors++;
        $display("FAIL packet_timeout: bytes %0d want %0d", idx, plen + 2);
        return;
      end
      if (abort_after >= 0 && idx == 2 + abort_after) return;
      px_if.data  = 8'($urandom);
      px_if.valid = ($urandom_range(99) < vp);
      ep_if.ready = ($urandom_range(99) < rp);
      if (idx == 0 && hold < hold_hdr0) begin
        ep_if.ready = 1'b0;
        hold++;
      end
      if (sof_on_final && idx == plen + 1) begin
        px_if.valid = 1'b1; ep_if.ready = 1'b1; sof = 1'b1;
      end
      @(negedge clk);
      chk_pulses();
      checks++;
      if (idx < 2) begin
        exp_b = (idx == 0) ? 8'h02 : bfh;
        if (ep_if.valid !== 1'b1 || ep_if.data !== exp_b || px_if.ready !== 1'b0) begin
          errors++;
          $display("FAIL header%0d: valid=%b data=%h px_ready=%b want 1 %h 0",
                   idx, ep_if.valid, ep_if.data, px_if.ready, exp_b);
        end
        hs = ep_if.ready;
      end else begin
        if (ep_if.valid !== px_if.valid || px_if.ready !== ep_if.ready ||
            (px_if.valid && ep_if.data !== px_if.data)) begin
          errors++;
          $display("FAIL payload byte %0d: valid=%b data=%h ready=%b want %b %h %b",
                   idx - 2, ep_if.valid, ep_if.data, px_if.ready, px_if.valid,
                   px_if.data, ep_if.ready);
        end
        hs = px_if.valid && ep_if.ready;
      end
      if (hs) begin
        if (idx == 1 && start0) exp_vf = 1'b1;
        if (idx >= 2) m_foff++;
        if (idx == plen + 1 && last) begin
          m_foff = 0; m_fid = ~m_fid; m_err = 1'b0; exp_fd = 1'b1;
        end
        idx++;
      end
      @(posedge clk); #1;
      sof = 1'b0;
      cyc++;
    end
    px_if.valid = 1'b0; ep_if.ready = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({ep_if.valid, px_if.ready, vf_sof, frame_done, underrun, fid} !== 6'b0 ||
        ep_if.data !== 8'h00) begin
      errors++;
      $display("FAIL reset: valid/ready/vf/fd/un/fid=%b%b%b%b%b%b data=%h want all 0",
               ep_if.valid, px_if.ready, vf_sof, frame_done, underrun, fid, ep_if.data);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_frame();
    stream_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      issue_sof(1'b0);
      run_packet(-1, 0, 1'b0, 100, 100);
    end
    idle(2);
    chk_fid();
    for (int i = 0; i < 3; i++) begin
      issue_sof(1'b0);
      run_packet(-1, 0, 1'b0, 70, 70);
    end
    idle(2);
    chk_fid();
  endtask

  task automatic test_underrun();
    issue_sof(1'b0);
    run_packet(2, 0, 1'b0, 100, 100);
    issue_sof(1'b1);
    run_packet(-1, 0, 1'b0, 80, 80);
    issue_sof(1'b0);
    run_packet(-1, 0, 1'b0, 80, 80);
    idle(2);
    issue_sof(1'b0);
    run_packet(-1, 0, 1'b0, 100, 100);
    idle(1);
  endtask

  task automatic test_hdr_stall();
    for (int i = 0; i < 2; i++) begin
      issue_sof(1'b0);
      run_packet(-1, 5, 1'b0, 90, 90);
    end
    idle(1);
  endtask

  task automatic test_stream_en();
    bit fid_before;
    issue_sof(1'b0);
    run_packet(-1, 0, 1'b0, 100, 100);
    stream_en = 1'b0;
    issue_sof(1'b0);
    idle(3);
    stream_en = 1'b1;
    issue_sof(1'b0);
    run_packet(1, 0, 1'b0, 100, 100);
    stream_en = 1'b0;
    issue_sof(1'b1);
    idle(2);
    fid_before = m_fid;
    chk_fid();
    stream_en = 1'b1;
    issue_sof(1'b0);
    run_packet(-1, 0, 1'b0, 100, 100);
    idle(1);
    checks++;
    if (fid !== fid_before) begin
      errors++;
      $display("FAIL fid_after_reenable: got %b want %b", fid, fid_before);
    end
  endtask

  task automatic test_back_to_back();
    bit chained, sf;
    chained = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (!chained) issue_sof(1'b0);
      sf = 1'($urandom_range(1));
      run_packet(-1, 0, sf, $urandom_range(100, 50), $urandom_range(100, 50));
      chained = sf;
    end
    if (chained) run_packet(-1, 0, 1'b0, 100, 100);
    idle(2);
    chk_fid();
  endtask

  task automatic test_reset_mid();
    issue_sof(1'b0);
    run_packet(1, 0, 1'b0, 100, 100);
    px_if.valid = 1'b1; ep_if.ready = 1'b1;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({ep_if.valid, px_if.ready, vf_sof, frame_done, underrun, fid} !== 6'b0 ||
        ep_if.data !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid: valid/ready/vf/fd/un/fid=%b%b%b%b%b%b data=%h want all 0",
               ep_if.valid, px_if.ready, vf_sof, frame_done, underrun, fid, ep_if.data);
    end
    m_foff = 0; m_fid = 1'b0; m_err = 1'b0;
    exp_vf = 1'b0; exp_fd = 1'b0; exp_un = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    px_if.valid = 1'b0; ep_if.ready = 1'b0;
    issue_sof(1'b0);
    run_packet(-1, 0, 1'b0, 100, 100);
    idle(2);
    chk_fid();
  endtask

  initial begin
    px_if.data = '0; px_if.valid = 1'b0; ep_if.ready = 1'b0;
    test_reset();
    test_frame();
    test_underrun();
    test_hdr_stall();
    test_stream_en();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/usb_uvc_iso_scheduler.md
Name: usb_uvc_iso_scheduler

Overview:
- Sequences the isochronous video IN endpoint (EP81) of the UVC camera.
- On each USB start-of-frame, builds one UVC payload packet:
  - a 2-byte header (HLE, BFH);
  - then up to PACKET_SIZE-2 pixel bytes pulled from a byte-stream pixel source.
- Tracks the frame byte offset, FID/EOF/ERR header bits, stream enable and packet underruns.
- Sits between the pixel source/FIFO and the usbfs core EP81 valid/ready port.

Parameters:
- FRAME_BYTES, 460800: bytes per video frame (W*H*2); must be ≥1.
- PACKET_SIZE, 802: EP81 max packet size including the 2-byte header; range 3..1023.

Ports:
- clk  in  1  system clock (60 MHz).
- rst  in  1  asynchronous, active-high reset.
- stream_en  in  1  level; 1 = streaming alternate setting is selected and probe/commit is done.
- sof  in  1  one-cycle pulse at each USB frame start, from the usbfs core.
- px_data  in  8  pixel byte.
- px_valid  in  1  pixel byte available.
- px_ready  out  1  pixel byte consumed this cycle (when px_valid=1).
- ep_data  out  8  byte to EP81.
- ep_valid  out  1  byte valid.
- ep_ready  in  1  EP81 accepts the byte.
- vf_sof  out  1  pulse: first packet of a new video frame has started.
- frame_done  out  1  pulse: last byte of a video frame accepted.
- underrun  out  1  pulse: sof arrived before the current packet completed.
- fid  out  1  current frame ID bit.

Behaviour:
Constants
- PAYLOAD = PACKET_SIZE-2.
- Counters:
  - frame offset `foff`: 32-bit, range 0..FRAME_BYTES-1;
  - packet byte counter `bcnt`: 10-bit;
  - packet payload length `plen`: 10-bit.

Reset
- Asynchronous on rst=1: state=IDLE, foff=0, bcnt=0, fid=0, err=0.
- All outputs 0: ep_valid, px_ready, vf_sof, frame_done, underrun, ep_data.

States: IDLE, HDR0, HDR1, PAYLOAD, WAIT_SOF.
- IDLE / WAIT_SOF, on sof:
  - stream_en=1 → HDR0; latch plen = min(PAYLOAD, FRAME_BYTES-foff); latch last = (FRAME_BYTES-foff ≤ PAYLOAD).
  - stream_en=0 → IDLE; foff=0, err=0 (fid kept).
- HDR0:
  - ep_valid=1, ep_data=8'h02.
  - On ep_ready → HDR1.
- HDR1:
  - ep_valid=1, ep_data={1'b1, err, 4'b0000, last, fid}.
  - On ep_ready:
    - pulse vf_sof if foff==0;
    - → PAYLOAD, bcnt=0.
- PAYLOAD (combinational pass-through):
  - ep_data=px_data, ep_valid=px_valid, px_ready=ep_ready.
  - On handshake (px_valid&ep_ready): bcnt+1, foff+1.
  - When bcnt+1==plen:
    - if last: foff=0, fid toggles, err=0, frame_done pulse;
    - → WAIT_SOF.
- Outside PAYLOAD: px_ready=0.

Latency
- ep_valid rises in the cycle after sof.
- Payload adds no cycle latency.

Boundary conditions
- sof in HDR0/HDR1/PAYLOAD (packet incomplete):
  - underrun pulse, err=1, packet abandoned (ep_valid drops);
  - foff keeps the bytes already sent;
  - restart at HDR0 with plen recomputed;
  - header of this and every later packet of the frame carries ERR=1 until frame_done.
- sof in the same cycle as the final payload handshake: the packet counts as complete (no underrun), its completion actions apply, and the next packet starts at HDR0.
- stream_en low sampled at any sof while busy: abort, no underrun pulse, go IDLE, foff=0, err=0.
- FRAME_BYTES ≤ PAYLOAD: every packet is the last one; fid toggles every packet.
- FRAME_BYTES multiple of PAYLOAD: the last packet is full, with EOF=1.
- foff never exceeds FRAME_BYTES-1; plen is never 0 while in PAYLOAD.

Decomposition:
- Package usb_uvc_pkg holds:
  - state enum;
  - UVC_HLE=8'h02;
  - BFH bit positions (FID=0, EOF=1, ERR=6, EOH=7).
- Single module; no sub-module is needed (the min/last computation is inline).

Test Plan:
- FRAME_BYTES=10, PACKET_SIZE=6, stream_en=1, px always valid, 3 sofs:
  - packets 02,80,+4B / 02,80,+4B / 02,82,+2B;
  - vf_sof on packet 1; frame_done after byte 10; fid=1.
- Continue with 3 more sofs:
  - BFH bytes 81,81,83;
  - fid returns to 0.
- px_valid withheld after 2 payload bytes of packet 1, then sof:
  - underrun pulse, ep_valid drops;
  - next header BFH=C0 with payload 4 bytes (foff 2..5);
  - following packet BFH=C2 with 4 bytes; err clears after frame_done.
- ep_ready held low 5 cycles during HDR0:
  - ep_data stays 02;
  - no byte is lost or duplicated.
- stream_en=0 at the sof after packet 1:
  - IDLE, no ep_valid;
  - re-enable: next packet has foff=0 with a vf_sof pulse, fid unchanged.
- rst pulse mid-PAYLOAD:
  - outputs 0 and fid=0 at once;
  - next sof starts a clean frame with BFH=80.
